// File: rtl/torrence_types.sv
// Shared types and width helpers for the cache refill engine.
package torrence_types;

  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = WORD_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } refill_state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_bits(input int xlen, input int beat_words);
    return xlen * beat_words;
  endfunction

endpackage

// File: rtl/cache_refill_engine_wrap_counter.sv
// Beat counter: loadable start index wrapping modulo BEATS; `last` tracks
// how many beats have moved, not where the index currently points.
module wrap_counter #(
  parameter int BEATS = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] start,
  input  logic         tick,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      cnt <= '0;
    end else if (load) begin
      idx <= start;
      cnt <= '0;
    end else if (tick) begin
      idx <= (idx == W'(BEATS - 1)) ? '0 : idx + 1'b1;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == W'(BEATS - 1));

endmodule

// File: rtl/cache_refill_engine.sv
// Burst writeback/fill engine between the cache data array and higher memory.
// CACHE_REFILL_CWF_EN selects critical-word-first wrap order with early restart.
module cache_refill_engine
  import torrence_types::*;
#(
  parameter int LINE_SIZE  = 32,
  parameter int XLEN       = 32,
  parameter int BEAT_WORDS = 1,
  localparam int OFS_SIZE         = $clog2(LINE_SIZE),
  localparam int WORD_SELECT_SIZE = clog2_min1(LINE_SIZE / WORD_BYTES),
  localparam int BEATS            = LINE_SIZE / (WORD_BYTES * BEAT_WORDS),
  localparam int BSEL_W           = clog2_min1(BEATS),
  localparam int BEAT_W           = beat_bits(XLEN, BEAT_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_fill,
  input  logic                        start_writeback,
  input  logic [XLEN-OFS_SIZE-1:0]    fill_block_address,
  input  logic [XLEN-OFS_SIZE-1:0]    wb_block_address,
  input  logic [WORD_SELECT_SIZE-1:0] fill_word_select,
  output logic                        hmem_req_valid,
  input  logic                        hmem_req_ready,
  output logic                        hmem_req_write,
  output logic [XLEN-1:0]             hmem_req_address,
  output logic [BEAT_W-1:0]           hmem_store_beat,
  input  logic                        hmem_resp_valid,
  input  logic [BEAT_W-1:0]           hmem_loaded_beat,
  output logic [BSEL_W-1:0]           array_beat_select,
  output logic                        array_write,
  input  logic [BEAT_W-1:0]           array_read_data,
  output logic                        critical_valid,
  output logic [XLEN-1:0]             critical_word,
  output logic                        busy,
  output logic                        done
);

  localparam int SUB_SH   = $clog2(BEAT_WORDS);
  localparam int BEAT_OFS = $clog2(WORD_BYTES * BEAT_WORDS);
  localparam int BLK_W    = XLEN - OFS_SIZE;

  refill_state_e state, next_state;

  logic [BLK_W-1:0]            fill_blk_q, wb_blk_q;
  logic [WORD_SELECT_SIZE-1:0] fill_word_q;
  logic                        fill_pending;

  logic              cnt_load, cnt_tick, beat_last;
  logic [BSEL_W-1:0] cnt_start, fill_start, beat_idx;

  logic [BSEL_W-1:0] crit_beat;
  logic              crit_hit;
  logic [XLEN-1:0]   crit_word_sel;
  int                crit_sub;

  function automatic logic [XLEN-1:0] beat_addr(input logic [BLK_W-1:0] blk,
                                                input logic [BSEL_W-1:0] b);
    return {blk, {OFS_SIZE{1'b0}}} | (XLEN'(b) << BEAT_OFS);
  endfunction

  wrap_counter #(.BEATS(BEATS), .W(BSEL_W)) u_beat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .start (cnt_start),
    .tick  (cnt_tick),
    .idx   (beat_idx),
    .last  (beat_last)
  );

`ifdef CACHE_REFILL_CWF_EN
  // From IDLE the latches are not loaded yet, so take the live select.
  logic [WORD_SELECT_SIZE-1:0] word_src;
  assign word_src   = (state == IDLE) ? fill_word_select : fill_word_q;
  assign fill_start = BSEL_W'(word_src >> SUB_SH);
`else
  assign fill_start = '0;
`endif

  assign crit_beat     = BSEL_W'(fill_word_q >> SUB_SH);
  assign crit_sub      = int'(fill_word_q) % BEAT_WORDS;
  assign crit_word_sel = hmem_loaded_beat[crit_sub*XLEN +: XLEN];
  assign crit_hit      = (state == FILL_WAIT) && hmem_resp_valid && (beat_idx == crit_beat);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_tick   = 1'b0;
    cnt_start  = fill_start;
    case (state)
      IDLE: begin
        if (start_writeback) begin
          next_state = WB_REQ;
          cnt_load   = 1'b1;
          cnt_start  = '0;
        end else if (start_fill) begin
          next_state = FILL_REQ;
          cnt_load   = 1'b1;
        end
      end
      WB_REQ: begin
        cnt_tick = hmem_req_ready;
        if (hmem_req_ready && beat_last) begin
          next_state = fill_pending ? FILL_REQ : DONE;
          cnt_load   = fill_pending;
        end
      end
      FILL_REQ:  if (hmem_req_ready) next_state = FILL_WAIT;
      FILL_WAIT: begin
        cnt_tick = hmem_resp_valid;
        if (hmem_resp_valid) next_state = beat_last ? DONE : FILL_REQ;
      end
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

`ifndef CACHE_REFILL_CWF_EN
  logic [XLEN-1:0] crit_q;
  logic            crit_q_vld;

  // Without early restart the critical word is held and reported with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      crit_q     <= '0;
      crit_q_vld <= 1'b0;
    end else if (state == IDLE) begin
      crit_q_vld <= 1'b0;
    end else if (crit_hit) begin
      crit_q     <= crit_word_sel;
      crit_q_vld <= 1'b1;
    end
  end
`endif

  always_comb begin
    hmem_req_valid    = 1'b0;
    hmem_req_write    = 1'b0;
    hmem_req_address  = '0;
    hmem_store_beat   = '0;
    array_write       = 1'b0;
    array_beat_select = beat_idx;
    busy              = (state != IDLE);
    done              = (state == DONE);
    case (state)
      WB_REQ: begin
        hmem_req_valid   = 1'b1;
        hmem_req_write   = 1'b1;
        hmem_req_address = beat_addr(wb_blk_q, beat_idx);
        hmem_store_beat  = array_read_data;
      end
      FILL_REQ: begin
        hmem_req_valid   = 1'b1;
        hmem_req_address = beat_addr(fill_blk_q, beat_idx);
      end
      FILL_WAIT: array_write = hmem_resp_valid;
      default: ;
    endcase
`ifdef CACHE_REFILL_CWF_EN
    critical_valid = crit_hit;
    critical_word  = crit_hit ? crit_word_sel : '0;
`else
    critical_valid = (state == DONE) && crit_q_vld;
    critical_word  = critical_valid ? crit_q : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_blk_q   <= '0;
      wb_blk_q     <= '0;
      fill_word_q  <= '0;
      fill_pending <= 1'b0;
    end else if (state == IDLE) begin
      if (start_fill) begin
        fill_blk_q  <= fill_block_address;
        fill_word_q <= fill_word_select;
      end
      if (start_writeback) wb_blk_q <= wb_block_address;
      fill_pending <= start_writeback & start_fill;
    end else if (cnt_load) begin
      fill_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine (LINE_SIZE=32, BEAT_WORDS=2, 4 beats).
module tb_cache_refill_engine;

  logic        clk = 1'b0;
  logic        reset, start_fill, start_writeback;
  logic [26:0] fill_block_address, wb_block_address;
  logic [2:0]  fill_word_select;
  logic        hmem_req_valid, hmem_req_ready, hmem_req_write;
  logic [31:0] hmem_req_address;
  logic [63:0] hmem_store_beat, hmem_loaded_beat, array_read_data;
  logic        hmem_resp_valid;
  logic [1:0]  array_beat_select;
  logic        array_write, critical_valid, busy, done;
  logic [31:0] critical_word;

  cache_refill_engine #(.LINE_SIZE(32), .XLEN(32), .BEAT_WORDS(2)) dut (
    .clk(clk), .reset(reset), .start_fill(start_fill), .start_writeback(start_writeback),
    .fill_block_address(fill_block_address), .wb_block_address(wb_block_address),
    .fill_word_select(fill_word_select), .hmem_req_valid(hmem_req_valid),
    .hmem_req_ready(hmem_req_ready), .hmem_req_write(hmem_req_write),
    .hmem_req_address(hmem_req_address), .hmem_store_beat(hmem_store_beat),
    .hmem_resp_valid(hmem_resp_valid), .hmem_loaded_beat(hmem_loaded_beat),
    .array_beat_select(array_beat_select), .array_write(array_write),
    .array_read_data(array_read_data), .critical_valid(critical_valid),
    .critical_word(critical_word), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            wb, fill;
    logic [26:0]     wb_blk, fill_blk;
    logic [2:0]      word;
    int              stall_lo, stall_hi, stray_rel, rst_rel;
    int              n_acc;
    logic [7:0][31:0] addr;
    logic [7:0]      wr;
    int              n_aw, done_rel, crit_rel;
    logic [31:0]     crit;
  } vec_t;

  localparam int NONE = -1000;
  vec_t vt[6];
  vec_t cur;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, s_cyc = 1 << 20, r, mr;
  logic hard_rst;
  logic fill_acc = 1'b0;
  logic [31:0] acc_addr = '0, last_fill = '0;
  logic [32:0] acc_q[$];
  int done_q[$], crel_q[$];
  logic [31:0] cword_q[$];
  int aw_n = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Array contents and memory returns are simple functions of the beat/address.
  function automatic logic [63:0] arr_model(input logic [1:0] b);
    logic [31:0] w0;
    w0 = 32'hA000_0000 + 32'(b) * 16;
    return {w0 + 32'd1, w0};
  endfunction

  function automatic logic [63:0] mem_beat(input logic [31:0] a);
    return {4'hD, a[27:0] + 28'd4, 4'hD, a[27:0]};
  endfunction

  function automatic logic [7:0][31:0] a8(input logic [31:0] a0, a1, a2, a3,
                                          input logic [31:0] a4 = 0, a5 = 0, a6 = 0, a7 = 0);
    logic [7:0][31:0] v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    return v;
  endfunction

  function automatic vec_t mkv(input logic wb, fill, input logic [26:0] wblk, fblk,
                               input logic [2:0] word, input int slo, shi, stray, rst, nacc,
                               input logic [7:0][31:0] addr, input logic [7:0] wr,
                               input int naw, drel, crel, input logic [31:0] crit);
    vec_t v;
    v.wb = wb; v.fill = fill; v.wb_blk = wblk; v.fill_blk = fblk; v.word = word;
    v.stall_lo = slo; v.stall_hi = shi; v.stray_rel = stray; v.rst_rel = rst;
    v.n_acc = nacc; v.addr = addr; v.wr = wr; v.n_aw = naw;
    v.done_rel = drel; v.crit_rel = crel; v.crit = crit;
    return v;
  endfunction

  always_comb array_read_data = arr_model(array_beat_select);

  // Stimulus driver; rel cycle 1 is the cycle the start pulse is high.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    r = cyc - s_cyc + 1;
    reset              = hard_rst || (r == cur.rst_rel);
    start_writeback    = (r == 1) && cur.wb;
    start_fill         = ((r == 1) && cur.fill) || (r == cur.stray_rel);
    fill_block_address = cur.fill_blk;
    wb_block_address   = cur.wb_blk;
    fill_word_select   = cur.word;
    hmem_req_ready     = !(r >= cur.stall_lo && r <= cur.stall_hi);
    hmem_resp_valid    = (fill_acc && r != cur.rst_rel) || (r == cur.stray_rel) ||
                         (cur.rst_rel > 0 && r == cur.rst_rel + 2);
    hmem_loaded_beat   = fill_acc ? mem_beat(acc_addr) : {2{32'hDEAD_BEEF}};
  end

  always @(negedge clk) begin
    mr = cyc - s_cyc + 1;
    if (mr == 1) begin
      acc_q.delete(); done_q.delete(); crel_q.delete(); cword_q.delete(); aw_n = 0;
    end
    fill_acc = hmem_req_valid && hmem_req_ready && !hmem_req_write;
    acc_addr = hmem_req_address;
    if (hmem_req_valid && hmem_req_ready) begin
      acc_q.push_back({hmem_req_write, hmem_req_address});
      if (hmem_req_write) chk("wb_store_data", hmem_store_beat, arr_model(hmem_req_address[4:3]));
      else last_fill = hmem_req_address;
    end
    if (array_write) begin
      aw_n++;
      chk("array_write_beat", array_beat_select, last_fill[4:3]);
    end
    if (done) done_q.push_back(mr);
    if (critical_valid) begin
      crel_q.push_back(mr);
      cword_q.push_back(critical_word);
    end
    if (mr >= cur.stall_lo && mr <= cur.stall_hi)
      chk("stall_hold", {hmem_req_valid, hmem_req_address, hmem_store_beat},
          {1'b1, cur.addr[1], arr_model(cur.addr[1][4:3])});
    if (cur.rst_rel > 0 && mr == cur.rst_rel + 1)
      chk("post_reset_zero", {hmem_req_valid, hmem_req_write, hmem_req_address, hmem_store_beat,
          array_write, critical_valid, critical_word, busy, done, array_beat_select}, '0);
  end

  initial begin
    logic [7:0][31:0] fa, ga0, ga7, wf;
    int cr0, cr1, cr5;
    cur = mkv(0, 0, 0, 0, 0, NONE, NONE, NONE, NONE, 0, '0, '0, 0, NONE, NONE, 0);
    hard_rst = 1'b1;
`ifdef CACHE_REFILL_CWF_EN
    fa  = a8(32'h1000_00D0, 32'h1000_00D8, 32'h1000_00C0, 32'h1000_00C8);
    ga7 = a8(32'h0000_1018, 32'h0000_1000, 32'h0000_1008, 32'h0000_1010);
    cr0 = 3; cr1 = 7; cr5 = 3;
`else
    fa  = a8(32'h1000_00C0, 32'h1000_00C8, 32'h1000_00D0, 32'h1000_00D8);
    ga7 = a8(32'h0000_1000, 32'h0000_1008, 32'h0000_1010, 32'h0000_1018);
    cr0 = 10; cr1 = 14; cr5 = NONE;
`endif
    ga0 = a8(32'h0000_1000, 32'h0000_1008, 32'h0000_1010, 32'h0000_1018);
    wf  = a8(32'h1000_0200, 32'h1000_0208, 32'h1000_0210, 32'h1000_0218,
             fa[0], fa[1], fa[2], fa[3]);
    // fill only, word 5 of line 0x1000_00C0
    vt[0] = mkv(0, 1, 0, 27'h080_0006, 3'd5, NONE, NONE, NONE, NONE,
                4, fa, 8'h00, 4, 10, cr0, 32'hD000_00D4);
    // writeback and fill requested together
    vt[1] = mkv(1, 1, 27'h080_0010, 27'h080_0006, 3'd5, NONE, NONE, NONE, NONE,
                8, wf, 8'h0F, 4, 14, cr1, 32'hD000_00D4);
    // writeback only, ready low for three cycles on beat 1
    vt[2] = mkv(1, 0, 27'h080_0010, 0, 3'd0, 3, 5, NONE, NONE,
                4, wf, 8'h0F, 0, 9, NONE, 0);
    // word 0, stray response and start_fill while busy
    vt[3] = mkv(0, 1, 0, 27'h000_0080, 3'd0, NONE, NONE, 4, NONE,
                4, ga0, 8'h00, 4, 10, (cr0 == 3) ? 3 : 10, 32'hD000_1000);
    // word 7: critical beat is the last one, wraps to 0
    vt[4] = mkv(0, 1, 0, 27'h000_0080, 3'd7, NONE, NONE, NONE, NONE,
                4, ga7, 8'h00, 4, 10, cr0, 32'hD000_101C);
    // reset in the third fill wait, late response afterwards
    vt[5] = mkv(0, 1, 0, 27'h080_0006, 3'd5, NONE, NONE, NONE, 7,
                3, fa, 8'h00, 2, NONE, cr5, 32'hD000_00D4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {hmem_req_valid, hmem_req_write, hmem_req_address, hmem_store_beat,
        array_write, critical_valid, critical_word, busy, done, array_beat_select}, '0);
    hard_rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      cur   = vt[i];
      s_cyc = cyc + 1;
      repeat (24) @(negedge clk);
      chk($sformatf("v%0d_n_req", i), acc_q.size(), vt[i].n_acc);
      for (int j = 0; j < vt[i].n_acc && j < acc_q.size(); j++)
        chk($sformatf("v%0d_req%0d", i, j), acc_q[j], {vt[i].wr[j], vt[i].addr[j]});
      chk($sformatf("v%0d_n_array_write", i), aw_n, vt[i].n_aw);
      chk($sformatf("v%0d_n_done", i), done_q.size(), (vt[i].done_rel == NONE) ? 0 : 1);
      if (vt[i].done_rel != NONE && done_q.size() > 0)
        chk($sformatf("v%0d_done_cycle", i), done_q[0], vt[i].done_rel);
      chk($sformatf("v%0d_n_critical", i), crel_q.size(), (vt[i].crit_rel == NONE) ? 0 : 1);
      if (vt[i].crit_rel != NONE && crel_q.size() > 0) begin
        chk($sformatf("v%0d_critical_cycle", i), crel_q[0], vt[i].crit_rel);
        chk($sformatf("v%0d_critical_word", i), cword_q[0], vt[i].crit);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_engine.md
# cache_refill_engine

Burst line-transfer engine between a cache datapath and higher memory, generalising the single-word, count-down miss-recovery sequencing to multi-word beats. It writes back a dirty victim line, then fills the missed line, optionally in critical-word-first wrap order with early restart of the requested word. It sits beside the cache datapath, driving the data-array port and the higher-memory request/response channel under control of the cache controller.

## Interface
- LINE_SIZE, 32, bytes per line; multiple of 4·BEAT_WORDS
- XLEN, 32, word width; only 32 supported
- BEAT_WORDS, 1, words per higher-memory beat (1, 2, 4); BEATS = LINE_SIZE/(4·BEAT_WORDS) ≥ 1
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start_fill  in  1  pulse: begin fill of fill_block_address
- start_writeback  in  1  pulse: begin writeback of wb_block_address
- fill_block_address / wb_block_address  in  XLEN-OFS_SIZE  line address (tag,set)
- fill_word_select  in  WORD_SELECT_SIZE  requested (critical) word index
- hmem_req_valid  out  1  request valid
- hmem_req_ready  in  1  request accepted when valid&ready
- hmem_req_write  out  1  1 = writeback beat, 0 = fill read
- hmem_req_address  out  XLEN  {block, beat_idx, zero byte/word bits}
- hmem_store_beat  out  XLEN·BEAT_WORDS  writeback data (= array_read_data)
- hmem_resp_valid  in  1  fill beat returned
- hmem_loaded_beat  in  XLEN·BEAT_WORDS  returned fill data
- array_beat_select  out  log2(BEATS) (min 1)  data-array beat index
- array_write  out  1  write hmem_loaded_beat into array this cycle
- array_read_data  in  XLEN·BEAT_WORDS  combinational array read at array_beat_select
- critical_valid  out  1  one-cycle pulse: critical_word valid
- critical_word  out  XLEN  requested word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse: whole operation complete

## Operation
- States: IDLE, WB_REQ, FILL_REQ, FILL_WAIT, DONE.
- IDLE: start_writeback → WB_REQ (beat 0); else start_fill → FILL_REQ. Both in same cycle: writeback first, fill latched and begun after last writeback beat. Starts while busy ignored.
- WB_REQ: hmem_req_valid=1, write=1, data from array at current beat; on accept advance beat; after last beat → FILL_REQ if fill pending, else DONE.
- FILL_REQ: hmem_req_valid=1, write=0; on accept → FILL_WAIT.
- FILL_WAIT: on hmem_resp_valid: array_write=1 for that beat, advance beat; last beat → DONE, else FILL_REQ.
- DONE: done=1 one cycle → IDLE.
- Beat order: writeback linear 0..BEATS-1; fill start beat = fill_word_select/BEAT_WORDS, wraps modulo BEATS (see Configuration).
- critical_word = word (fill_word_select mod BEAT_WORDS) of the critical beat.
- One outstanding request; hmem_resp_valid outside FILL_WAIT ignored.
- Address/data held stable while valid & !ready.

## Timing
- Reset: all outputs 0, state IDLE, pending fill cleared; reset mid-burst abandons transfer, later responses ignored.
- hmem_req_valid rises cycle after start.
- Fill beat: min 2 cycles (accept, response next cycle). Zero-wait fill: done at cycle 2·BEATS+2 after start.
- array_write, critical_valid combinational with hmem_resp_valid in FILL_WAIT (early restart same cycle).
- Writeback beat: 1 cycle when ready held high.

## Configuration
- CACHE_REFILL_CWF_EN defined: fill starts at critical beat and wraps; critical_valid pulses with the critical beat's response.
- Undefined: fill linear from beat 0; critical word captured into a register on its beat; critical_valid pulses in the DONE cycle with that register.

## Structure
- torrence_types: refill_state_e enum; BEAT-width helper constants derived there from XLEN.
- Sub-module wrap_counter: loadable start value, tick, modulo-BEATS wrap, last-beat flag (counts beats transferred, not index).

## Test plan
- LINE_SIZE=32, BEAT_WORDS=2 (4 beats), CWF on, fill addr 0x1000_00C0>>5, word 5, ready=1, resp next cycle → addresses 0x…C8? no: beats 2,3,0,1 → 0x1000_00D0,D8,C0,C8; critical_valid on first response, done cycle 10.
- Same, CWF off → beats 0,1,2,3; critical_valid only with done.
- start_writeback+start_fill same cycle → 4 write beats beat 0..3 with array data, then 4 fill beats, single done.
- hmem_req_ready low 3 cycles during beat 1 → valid, address, store data stable; no beat skipped.
- reset asserted in FILL_WAIT of beat 2 → outputs 0 next cycle; late hmem_resp_valid causes no array_write.
- Stray hmem_resp_valid and start_fill while busy → ignored, sequence unchanged.
